alu_mc_g7: RTL and testbench
============================

Name: alu_mc_g7

Overview:
Parametrised multi-cycle ALU, the successor of the single-cycle execute ALU.
- Executes all base RV32I ALU ops in one registered cycle.
- Adds iterative multiply/divide (M-extension subset) taking XLEN cycles.
- Sits in the EX stage. Control stalls the pipeline while busy is high and captures result on out_valid.

Parameters:
- XLEN, 32: operand/result width; power of two, minimum 8.
- SHW, $clog2(XLEN): shift-amount width, derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request strobe; accepted only when ready=1.
- ALUControl  input  5  operation code from the shared defines header.
- a  input  XLEN  operand A (rs1 / dividend / multiplicand).
- b  input  XLEN  operand B (rs2 / divisor / multiplier / shift amount).
- ready  output  1  block idle, can accept a request.
- busy  output  1  iterative op in progress; equals ~ready.
- out_valid  output  1  one-cycle pulse: result and zero are fresh.
- result  output  XLEN  registered result; held until the next completion.
- zero  output  1  registered (result == 0); updated with result.

Behaviour:
- Reset (synchronous, wins over everything, aborts any op in progress):
  - state=IDLE, ready=1, busy=0, out_valid=0, result=0, zero=1.
  - All iteration registers cleared.
- States:
  - IDLE: ready=1.
  - ITER: busy=1.
  - DONE: one cycle, out_valid=1; returns to IDLE.
- Accept rule: accept happens on an edge where in_valid=1 and ready=1; a and b are latched then.
  - in_valid while busy is ignored; no queueing.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Accept at edge k: result is written at edge k and out_valid=1 in cycle k+1.
  - State goes IDLE->DONE->IDLE. ready=0 during the DONE cycle, so back-to-back throughput is one op per 2 cycles.
- Shifts use b[SHW-1:0]. SRA is arithmetic.
- SLT is signed and SLTU unsigned; each returns 0 or 1, zero-extended.
- Iterative ops: MUL (low XLEN), MULHU (high XLEN), DIVU, REMU.
  - Accept at edge k -> ITER for exactly XLEN edges -> DONE -> out_valid=1 in cycle k+XLEN+1.
  - Latency is fixed and independent of the operand values.
- MUL/MULHU: radix-2 shift-add into a 2*XLEN accumulator.
- DIVU/REMU: restoring division, one quotient bit per cycle.
- Divide by zero:
  - DIVU -> all ones.
  - REMU -> a.
  - No trap; normal latency.
- Undefined ALUControl: single-cycle path, result=0, zero=1. Never X.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- result and zero change only at DONE entry. Between completions they hold their last values.

Optional Feature:
- Macro: ALU_MC_SIGNED_MD_EN.
- Defined: adds MULH, MULHSU, DIV and REM.
  - Operands are converted to magnitude at accept; the sign is fixed up in the DONE transition.
  - Latency is the same XLEN+1.
  - DIV by zero -> -1; REM by zero -> a.
  - DIV of most-negative by -1 -> most-negative; REM of the same -> 0.
- Undefined: these four codes are treated as undefined (result=0).

Decomposition:
- riscv_defines_g7.v acts as the shared package. It holds:
  - all 5-bit ALU_* op codes (the existing codes plus ALU_XOR, ALU_SLL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU);
  - the state encodings ST_IDLE, ST_ITER and ST_DONE.
- One sub-module, alu_md_iter_g7:
  - iterative shift-add / restoring-subtract datapath with an XLEN-count iteration counter;
  - start/done interface;
  - operates on unsigned magnitudes only.
- The top level holds the FSM, the single-cycle ops, the sign handling and the output registers.

Test Plan:
- Reset then idle: reset high 2 cycles -> ready=1, out_valid=0, result=0, zero=1.
- ADD a=0x7FFFFFFF, b=1 -> out_valid next cycle, result=0x80000000, zero=0. Then SUB 5-5 -> result=0, zero=1.
- SRA a=0x80000000, b=0x21 (shamt=1) -> 0xC0000000. SLTU a=1, b=0xFFFFFFFF -> 1.
- MUL a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE. Then MULHU on the same operands -> 1. in_valid held during busy is ignored.
- DIVU a=100, b=7 -> 14; REMU -> 2. DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5.
- Reset asserted at iteration 10 of a DIVU -> no out_valid, ready=1 the cycle after reset. With ALU_MC_SIGNED_MD_EN, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.

Source files
------------

// File: rtl/alu_mc_g7_pkg.sv
// Shared op codes, FSM state encodings and op classification for the multi-cycle ALU.
// Optional macro ALU_MC_SIGNED_MD_EN turns MULH, MULHSU, DIV and REM into iterative ops.
package alu_mc_g7_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [4:0] op);
        logic r;
        case (op)
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: r = 1'b1;
`ifdef ALU_MC_SIGNED_MD_EN
            ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        logic r;
        case (op)
            ALU_DIVU, ALU_REMU: r = 1'b1;
`ifdef ALU_MC_SIGNED_MD_EN
            ALU_DIV, ALU_REM: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_md_iter_g7.sv
// Unsigned iterative multiply (shift-add) / divide (restoring) datapath, one step per cycle.
// hi/lo hold the product halves while multiplying and remainder/quotient while dividing.
module alu_md_iter_g7 #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            done,
    output logic [XLEN-1:0] res_lo,
    output logic [XLEN-1:0] res_hi
);
    import alu_mc_g7_pkg::*;

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            div_q, div_d;
    logic [XLEN:0]   sum_s, shl_s, diff_s;

    // Next-state for one iteration step or operand load.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        div_d  = div_q;
        done   = 1'b0;
        sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        shl_s  = {hi_q, lo_q[XLEN-1]};
        diff_s = shl_s - {1'b0, opnd_q};
        if (start) begin
            hi_d   = {XLEN{1'b0}};
            lo_d   = is_div ? a_mag : b_mag;
            opnd_d = is_div ? b_mag : a_mag;
            cnt_d  = {SHW{1'b0}};
            run_d  = 1'b1;
            div_d  = is_div;
        end else if (run_q) begin
            if (div_q) begin
                // Borrow out of the trial subtraction means restore
                if (diff_s[XLEN]) begin
                    hi_d = shl_s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end else begin
                    hi_d = diff_s[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end
            end else begin
                hi_d = sum_s[XLEN:1];
                lo_d = {sum_s[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(XLEN - 1)) begin
                done  = 1'b1;
                run_d = 1'b0;
            end else begin
                done  = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Iteration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= {XLEN{1'b0}};
            lo_q   <= {XLEN{1'b0}};
            opnd_q <= {XLEN{1'b0}};
            cnt_q  <= {SHW{1'b0}};
            run_q  <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            div_q  <= div_d;
        end
    end

    assign res_lo = lo_d;
    assign res_hi = hi_d;

endmodule

// File: rtl/alu_mc_g7.sv
// Multi-cycle EX-stage ALU: single-cycle RV32I ops plus iterative MUL/MULHU/DIVU/REMU.
// Defining ALU_MC_SIGNED_MD_EN adds MULH, MULHSU, DIV and REM via sign-magnitude handling.
module alu_mc_g7 #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4:0]      ALUControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    import alu_mc_g7_pkg::*;

    state_e          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            md_start_s, md_is_div_s, md_done_s;
    logic [XLEN-1:0] md_a_s, md_b_s, md_lo_s, md_hi_s;
    logic [XLEN-1:0] alu_res_s, iter_res_s;
    logic            slt_s, sltu_s;

`ifdef ALU_MC_SIGNED_MD_EN
    logic            neg_q, neg_d;
    logic            sa_s, sb_s;
`endif

    // Single-cycle result from the live operands.
    always_comb begin
        slt_s  = $signed(a) < $signed(b);
        sltu_s = a < b;
        case (ALUControl)
            ALU_ADD:  alu_res_s = a + b;
            ALU_SUB:  alu_res_s = a - b;
            ALU_AND:  alu_res_s = a & b;
            ALU_OR:   alu_res_s = a | b;
            ALU_XOR:  alu_res_s = a ^ b;
            ALU_SLL:  alu_res_s = a << b[SHW-1:0];
            ALU_SRL:  alu_res_s = a >> b[SHW-1:0];
            ALU_SRA:  alu_res_s = $signed(a) >>> b[SHW-1:0];
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, slt_s};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, sltu_s};
            default:  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Operand magnitudes handed to the unsigned datapath.
    always_comb begin
`ifdef ALU_MC_SIGNED_MD_EN
        sa_s = a[XLEN-1] && ((ALUControl == ALU_MULH) || (ALUControl == ALU_MULHSU) ||
                             (ALUControl == ALU_DIV)  || (ALUControl == ALU_REM));
        sb_s = b[XLEN-1] && ((ALUControl == ALU_MULH) || (ALUControl == ALU_DIV) ||
                             (ALUControl == ALU_REM));
        md_a_s = sa_s ? ((~a) + {{(XLEN-1){1'b0}}, 1'b1}) : a;
        md_b_s = sb_s ? ((~b) + {{(XLEN-1){1'b0}}, 1'b1}) : b;
`else
        md_a_s = a;
        md_b_s = b;
`endif
        md_is_div_s = is_div_op(ALUControl);
    end

    // Final iterative result, with sign fix-up for the signed variants.
    always_comb begin
        case (op_q)
            ALU_MUL:   iter_res_s = md_lo_s;
            ALU_MULHU: iter_res_s = md_hi_s;
            ALU_DIVU:  iter_res_s = md_lo_s;
            ALU_REMU:  iter_res_s = md_hi_s;
`ifdef ALU_MC_SIGNED_MD_EN
            // High half of a negated product only takes the carry when the low half is zero
            ALU_MULH, ALU_MULHSU:
                iter_res_s = neg_q ? ((~md_hi_s) + {{(XLEN-1){1'b0}}, (md_lo_s == {XLEN{1'b0}})})
                                   : md_hi_s;
            ALU_DIV:
                iter_res_s = neg_q ? ((~md_lo_s) + {{(XLEN-1){1'b0}}, 1'b1}) : md_lo_s;
            ALU_REM:
                iter_res_s = neg_q ? ((~md_hi_s) + {{(XLEN-1){1'b0}}, 1'b1}) : md_hi_s;
`endif
            default:   iter_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM next state and output register inputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        md_start_s = 1'b0;
`ifdef ALU_MC_SIGNED_MD_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = ALUControl;
`ifdef ALU_MC_SIGNED_MD_EN
                    // Divide by zero keeps the raw all-ones quotient, i.e. -1
                    case (ALUControl)
                        ALU_MULH:   neg_d = sa_s ^ sb_s;
                        ALU_MULHSU: neg_d = sa_s;
                        ALU_DIV:    neg_d = (sa_s ^ sb_s) && (b != {XLEN{1'b0}});
                        ALU_REM:    neg_d = sa_s;
                        default:    neg_d = 1'b0;
                    endcase
`endif
                    if (is_iter_op(ALUControl)) begin
                        state_d    = ST_ITER;
                        md_start_s = 1'b1;
                    end else begin
                        state_d    = ST_DONE;
                        result_d   = alu_res_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (md_done_s) begin
                    state_d  = ST_DONE;
                    result_d = iter_res_s;
                end else begin
                    state_d  = ST_ITER;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        zero_d      = (result_d == {XLEN{1'b0}});
        ready_d     = (state_d == ST_IDLE);
        busy_d      = ~ready_d;
        out_valid_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= ALU_ADD;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            zero_q      <= 1'b1;
`ifdef ALU_MC_SIGNED_MD_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
`ifdef ALU_MC_SIGNED_MD_EN
            neg_q       <= neg_d;
`endif
        end
    end

    alu_md_iter_g7 #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_s),
        .is_div (md_is_div_s),
        .a_mag  (md_a_s),
        .b_mag  (md_b_s),
        .done   (md_done_s),
        .res_lo (md_lo_s),
        .res_hi (md_hi_s)
    );

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc_g7.sv
// Self-checking bench for alu_mc_g7: latency/result reference model plus directed vectors.
module tb_alu_mc_g7;
    import alu_mc_g7_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        ready, busy, out_valid, zero;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_mc_g7 #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .ALUControl (op),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero)
    );

    function automatic bit m_iter(input logic [4:0] o);
        case (o)
            ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: return 1'b1;
`ifdef ALU_MC_SIGNED_MD_EN
            ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] pu;
        logic signed [63:0] ps;
        pu = {32'd0, x} * {32'd0, y};
        ps = 64'sd0;
        case (o)
            ALU_ADD:   return x + y;
            ALU_SUB:   return x - y;
            ALU_AND:   return x & y;
            ALU_OR:    return x | y;
            ALU_XOR:   return x ^ y;
            ALU_SLL:   return x << y[4:0];
            ALU_SRL:   return x >> y[4:0];
            ALU_SRA:   return $unsigned($signed(x) >>> y[4:0]);
            ALU_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (x < y) ? 32'd1 : 32'd0;
            ALU_MUL:   return pu[31:0];
            ALU_MULHU: return pu[63:32];
            ALU_DIVU:  return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            ALU_REMU:  return (y == 32'd0) ? x : x % y;
`ifdef ALU_MC_SIGNED_MD_EN
            ALU_MULH: begin
                ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return ps[63:32];
            end
            ALU_MULHSU: begin
                ps = $signed({{32{x[31]}}, x}) * $signed({32'd0, y});
                return ps[63:32];
            end
            ALU_DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $unsigned($signed(x) / $signed(y));
            end
            ALU_REM: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return $unsigned($signed(x) % $signed(y));
            end
`endif
            default:   return 32'd0;
        endcase
    endfunction

    // Reference: ready/out_valid timeline as a countdown, results from model()
    logic        ready_m = 1'b1;
    logic        valid_m = 1'b0;
    logic [31:0] res_m = 32'd0;
    logic [31:0] pend_m = 32'd0;
    int          remain_m = 0;

    always @(posedge clk) begin
        if (reset) begin
            ready_m  <= 1'b1;
            valid_m  <= 1'b0;
            res_m    <= 32'd0;
            remain_m <= 0;
        end else if (valid_m) begin
            valid_m <= 1'b0;
            ready_m <= 1'b1;
        end else if (remain_m > 0) begin
            remain_m <= remain_m - 1;
            if (remain_m == 1) begin
                valid_m <= 1'b1;
                res_m   <= pend_m;
            end
        end else if (ready_m && in_valid) begin
            ready_m <= 1'b0;
            if (m_iter(op)) begin
                remain_m <= XLEN;
                pend_m   <= model(op, a, b);
            end else begin
                valid_m <= 1'b1;
                res_m   <= model(op, a, b);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, ready}, {31'd0, ready_m});
            chk("busy", {31'd0, busy}, {31'd0, ~ready_m});
            chk("out_valid", {31'd0, out_valid}, {31'd0, valid_m});
            chk("result", result, res_m);
            chk("zero", {31'd0, zero}, {31'd0, (res_m == 32'd0)});
        end
    end

    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat_exp, input bit hold);
        int w;
        int lat;
        w = 0;
        while (ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        if (hold) begin
            a = ~x;
            b = 32'd3;
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk($sformatf("latency op%0d", o), lat, lat_exp);
        chk($sformatf("result op%0d a=%h b=%h", o, x, y), result, exp);
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd1);
        reset = 1'b0;
        chk_en = 1'b1;

        do_op(ALU_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1, 1'b0);
        chk("add zero", {31'd0, zero}, 32'd0);
        do_op(ALU_SUB,  32'd5,         32'd5,         32'd0,         1, 1'b0);
        chk("sub zero", {31'd0, zero}, 32'd1);
        do_op(ALU_SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1, 1'b0);
        do_op(ALU_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1,         1, 1'b0);
        do_op(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1, 1'b0);
        do_op(ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, 1, 1'b0);
        do_op(ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1, 1'b0);
        do_op(ALU_XOR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1, 1'b0);
        do_op(ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1, 1'b0);
        do_op(ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1, 1'b0);
        do_op(ALU_MUL,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 33, 1'b1);
        do_op(ALU_MULHU,32'hFFFF_FFFF, 32'd2,         32'd1,         33, 1'b0);
        do_op(ALU_DIVU, 32'd100,       32'd7,         32'd14,        33, 1'b0);
        do_op(ALU_REMU, 32'd100,       32'd7,         32'd2,         33, 1'b0);
        do_op(ALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, 1'b0);
        do_op(ALU_REMU, 32'd5,         32'd0,         32'd5,         33, 1'b0);
        do_op(5'd31,    32'h1234_5678, 32'd1,         32'd0,         1, 1'b0);
        chk("undef zero", {31'd0, zero}, 32'd1);
`ifdef ALU_MC_SIGNED_MD_EN
        do_op(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        do_op(ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0);
        do_op(ALU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        do_op(ALU_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        do_op(ALU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 33, 1'b0);
        do_op(ALU_REM,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 33, 1'b0);
        do_op(ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33, 1'b0);
        do_op(ALU_MULH,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        do_op(ALU_MULHSU,32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
`else
        do_op(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b0);
        do_op(ALU_MULH,  32'hFFFF_FFFF, 32'd2,         32'd0,         1, 1'b0);
`endif

        // Abort a divide partway through with reset
        do_op(ALU_ADD, 32'd1, 32'd2, 32'd3, 1, 1'b0);
        @(negedge clk);
        op = ALU_DIVU;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort ready", {31'd0, ready}, 32'd1);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort no out_valid", {31'd0, seen}, 32'd0);

        do_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
